updn_cntr_fsm: RTL and testbench
================================

Name: updn_cntr_fsm

Overview:
Parametrised up/down counter with a one-hot control FSM, a programmable upper limit and run-time terminal-count modes: stop, wrap or saturate. Separate sticky overflow and underflow flags, a terminal-count pulse, and synchronous load. Drop-in next generation of the team's 4-bit FSM counter for timer and event-count datapaths.

Parameters:
CNTR_WDTH, 8, counter width in bits.
TC_CNT_WDTH, 8, width of the terminal-event counter; used only when TC_CNT_EN is defined.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
act  in  1  counter activate.
up_dwn  in  1  1 = count up, 0 = count down.
mode  in  2  00 STOP, 01 WRAP, 10 SAT, 11 treated as STOP.
max_val  in  CNTR_WDTH  upper limit (inclusive).
load  in  1  synchronous load strobe.
load_val  in  CNTR_WDTH  load value.
ovf_clr  in  1  clears flags; exits OVRFLW.
count  out  CNTR_WDTH  counter value.
ovrflw  out  1  sticky, set on an up terminal event.
undrflw  out  1  sticky, set on a down terminal event.
tc_pls  out  1  registered 1-cycle pulse per terminal event.
state_o  out  4  current one-hot state.

Behaviour:
- Reset: count=0, state=IDLE, ovrflw=0, undrflw=0, tc_pls=0.
- Priority at each edge: rst > load > ovf_clr > normal operation.
- Load:
  - count <= (load_val > max_val) ? max_val : load_val.
  - state <= IDLE; ovrflw, undrflw and tc_pls cleared.
  - Load is legal in any state, including OVRFLW.
- ovf_clr: ovrflw=0, undrflw=0. OVRFLW -> IDLE with count held. In other states, state and count are unaffected.
- States are one-hot: IDLE 0001, CNT_UP 0010, CNT_DWN 0100, OVRFLW 1000.
- Stepping:
  - The step is governed by the registered state. Inputs decide only the next state.
  - One cycle of latency: act sampled at edge k enters CNT_UP/CNT_DWN; the first step occurs at edge k+1.
- IDLE: count held. Next state: act ? (up_dwn ? CNT_UP : CNT_DWN) : IDLE.
- CNT_UP step:
  - Terminal when count >= max_val. Use >= so a reduced max_val mid-count is safe.
  - Non-terminal: count+1.
- CNT_DWN step:
  - Terminal when count == 0.
  - Non-terminal: count-1.
- Terminal event, in all modes:
  - Sets ovrflw (up) or undrflw (down).
  - tc_pls=1 in the following cycle.
- Terminal event, per mode:
  - STOP: count held (clamped to max_val if above it). Next state is OVRFLW regardless of act.
  - WRAP: up -> count=0; down -> count=max_val. State continues.
  - SAT: count held (clamped to max_val). State continues. A terminal event recurs every cycle while pinned, so tc_pls stays high.
- Next state from CNT_UP/CNT_DWN, when not STOP-terminal: act=0 -> IDLE (the step at that edge still occurs); otherwise up_dwn selects CNT_UP or CNT_DWN. Direction reversal costs no idle cycle.
- OVRFLW: count and flags held. Exits only on ovf_clr, load or rst.
- mode and max_val are sampled every cycle; there is no shadowing.
- Arithmetic is modulo 2^CNTR_WDTH internally. No value above max_val is ever produced by stepping.
- Illegal state encoding: next state = IDLE (self-recovering).

Optional Feature:
UPDN_CNTR_TC_CNT_EN.
- Defined: adds output tc_cnt [TC_CNT_WDTH-1:0].
  - Increments on each terminal event and saturates at all-ones.
  - Cleared by rst, load and ovf_clr.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package updn_cntr_pkg: state one-hot localparams (IDLE, CNT_UP, CNT_DWN, OVRFLW) and mode encodings (MODE_STOP, MODE_WRAP, MODE_SAT).
- One sub-module, tc_event_cntr: the saturating event counter, instantiated only under UPDN_CNTR_TC_CNT_EN.
- FSM and datapath stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles mid-count (count=6) -> count=0, state_o=0001, ovrflw=undrflw=tc_pls=0.
- STOP up: WDTH=4, max_val=5, act=1, up_dwn=1 from 0 -> count 0,1,2,3,4,5, then state_o=1000, ovrflw=1, count=5 held. Then ovf_clr=1 -> state_o=0001, ovrflw=0, count=5.
- WRAP down: load_val=2, max_val=9, mode=01, act=1, up_dwn=0 -> count 2,1,0,9,8, undrflw=1. tc_pls high exactly one cycle, after the 0->9 step.
- SAT up: max_val=15, count=14 -> count 15 and stays 15, ovrflw=1, tc_pls continuously 1. Then up_dwn=0 -> 14, 13, and tc_pls drops.
- Load clamp: load_val=12, max_val=7 -> count=7, state IDLE. Load while in CNT_UP -> IDLE with the new value next cycle.
- Reversal and stop:
  - Count=3 in CNT_UP, up_dwn=0 -> count 4, then 3, 2.
  - act=0 at count=2 -> one more step to 1, then state IDLE with count held at 1.
  - Set max_val=0 in CNT_UP at count=3 -> immediate terminal event, count clamped to 0.

Source files
------------

// File: rtl/updn_cntr_pkg.sv
// rtl/updn_cntr_pkg.sv - shared state and mode encodings for the up/down counter
package updn_cntr_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    CNT_UP  = 4'b0010,
    CNT_DWN = 4'b0100,
    OVRFLW  = 4'b1000
  } state_t;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_SAT  = 2'b10;

endpackage

// File: rtl/tc_event_cntr.sv
// rtl/tc_event_cntr.sv - saturating count of terminal events
module tc_event_cntr #(
  parameter int WDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [WDTH-1:0] cnt
);

  localparam logic [WDTH-1:0] ONE = WDTH'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/updn_cntr_fsm.sv
// rtl/updn_cntr_fsm.sv - up/down counter with one-hot FSM, STOP/WRAP/SAT modes; UPDN_CNTR_TC_CNT_EN adds tc_cnt
module updn_cntr_fsm
  import updn_cntr_pkg::*;
#(
  parameter int CNTR_WDTH   = 8,
  parameter int TC_CNT_WDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   act,
  input  logic                   up_dwn,
  input  logic [1:0]             mode,
  input  logic [CNTR_WDTH-1:0]   max_val,
  input  logic                   load,
  input  logic [CNTR_WDTH-1:0]   load_val,
  input  logic                   ovf_clr,
`ifdef UPDN_CNTR_TC_CNT_EN
  output logic [TC_CNT_WDTH-1:0] tc_cnt,
`endif
  output logic [CNTR_WDTH-1:0]   count,
  output logic                   ovrflw,
  output logic                   undrflw,
  output logic                   tc_pls,
  output logic [3:0]             state_o
);

  localparam logic [CNTR_WDTH-1:0] ONE = CNTR_WDTH'(1);

  state_t                 state_q, state_d;
  logic [CNTR_WDTH-1:0]   count_q, count_d;
  logic                   ovrflw_q, ovrflw_d;
  logic                   undrflw_q, undrflw_d;
  logic                   tc_pls_q;
  logic                   term_ev;
  logic [CNTR_WDTH-1:0]   clamp_val;
  logic [CNTR_WDTH-1:0]   dec_val;
  state_t                 run_next;

  assign clamp_val = (count_q > max_val) ? max_val : count_q;
  assign dec_val   = ((count_q - ONE) > max_val) ? max_val : (count_q - ONE);
  assign run_next  = act ? (up_dwn ? CNT_UP : CNT_DWN) : IDLE;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovrflw_d  = ovrflw_q;
    undrflw_d = undrflw_q;
    term_ev   = 1'b0;
    if (load) begin
      count_d   = (load_val > max_val) ? max_val : load_val;
      state_d   = IDLE;
      ovrflw_d  = 1'b0;
      undrflw_d = 1'b0;
    end else if (ovf_clr) begin
      ovrflw_d  = 1'b0;
      undrflw_d = 1'b0;
      if (state_q == OVRFLW) state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = run_next;
        CNT_UP: begin
          state_d = run_next;
          if (count_q >= max_val) begin
            term_ev  = 1'b1;
            ovrflw_d = 1'b1;
            if (mode == MODE_WRAP) begin
              count_d = '0;
            end else begin
              count_d = clamp_val;
              if (mode != MODE_SAT) state_d = OVRFLW;
            end
          end else begin
            count_d = count_q + ONE;
          end
        end
        CNT_DWN: begin
          state_d = run_next;
          if (count_q == '0) begin
            term_ev   = 1'b1;
            undrflw_d = 1'b1;
            if (mode == MODE_WRAP) begin
              count_d = max_val;
            end else begin
              count_d = clamp_val;
              if (mode != MODE_SAT) state_d = OVRFLW;
            end
          end else begin
            count_d = dec_val;
          end
        end
        OVRFLW: state_d = OVRFLW;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      ovrflw_q  <= 1'b0;
      undrflw_q <= 1'b0;
      tc_pls_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ovrflw_q  <= ovrflw_d;
      undrflw_q <= undrflw_d;
      tc_pls_q  <= term_ev;
    end
  end

`ifdef UPDN_CNTR_TC_CNT_EN
  tc_event_cntr #(.WDTH(TC_CNT_WDTH)) u_tc_event_cntr (
    .clk (clk),
    .rst (rst),
    .clr (load | ovf_clr),
    .inc (term_ev),
    .cnt (tc_cnt)
  );
`endif

  assign count   = count_q;
  assign ovrflw  = ovrflw_q;
  assign undrflw = undrflw_q;
  assign tc_pls  = tc_pls_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_updn_cntr_fsm.sv
// tb/tb_updn_cntr_fsm.sv - scoreboard bench for updn_cntr_fsm (4-bit counter)
module tb_updn_cntr_fsm;

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_UP   = 4'b0010;
  localparam logic [3:0] S_DWN  = 4'b0100;
  localparam logic [3:0] S_OVR  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst, act, up_dwn, load, ovf_clr;
  logic [1:0] mode;
  logic [3:0] max_val, load_val;
  logic [3:0] count;
  logic       ovrflw, undrflw, tc_pls;
  logic [3:0] state_o;
`ifdef UPDN_CNTR_TC_CNT_EN
  logic [7:0] tc_cnt;
`endif

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic [3:0] st;
    logic       o;
    logic       u;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  updn_cntr_fsm #(.CNTR_WDTH(4), .TC_CNT_WDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .act      (act),
    .up_dwn   (up_dwn),
    .mode     (mode),
    .max_val  (max_val),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
`ifdef UPDN_CNTR_TC_CNT_EN
    .tc_cnt   (tc_cnt),
`endif
    .count    (count),
    .ovrflw   (ovrflw),
    .undrflw  (undrflw),
    .tc_pls   (tc_pls),
    .state_o  (state_o)
  );

  task automatic chk(input string name, input logic [3:0] cnt, input logic [3:0] st,
                     input logic o, input logic u, input logic t);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = name; e.cnt = cnt; e.st = st; e.o = o; e.u = u; e.t = t;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if ({count, state_o, ovrflw, undrflw, tc_pls} !== {e.cnt, e.st, e.o, e.u, e.t}) begin
        bad++;
        $display("FAIL %s: got count=%0d state=%b ovf=%b udf=%b tc=%b, want count=%0d state=%b ovf=%b udf=%b tc=%b",
                 e.name, count, state_o, ovrflw, undrflw, tc_pls, e.cnt, e.st, e.o, e.u, e.t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; act = 0; up_dwn = 1; mode = 2'b00; max_val = 4'd5;
    load = 0; load_val = 0; ovf_clr = 0;
    chk("reset0", 0, S_IDLE, 0, 0, 0);
    chk("reset1", 0, S_IDLE, 0, 0, 0);
    rst = 0;

    // STOP up to max_val=5
    act = 1; up_dwn = 1;
    chk("stop_enter", 0, S_UP, 0, 0, 0);
    chk("stop_c1", 1, S_UP, 0, 0, 0);
    chk("stop_c2", 2, S_UP, 0, 0, 0);
    chk("stop_c3", 3, S_UP, 0, 0, 0);
    chk("stop_c4", 4, S_UP, 0, 0, 0);
    chk("stop_c5", 5, S_UP, 0, 0, 0);
    chk("stop_term", 5, S_OVR, 1, 0, 1);
    chk("stop_hold", 5, S_OVR, 1, 0, 0);
    act = 0; ovf_clr = 1;
    chk("stop_clr", 5, S_IDLE, 0, 0, 0);
    ovf_clr = 0;

    // reset mid-count
    max_val = 9; mode = 2'b01; load = 1; load_val = 4;
    chk("mid_load", 4, S_IDLE, 0, 0, 0);
    load = 0; act = 1;
    chk("mid_enter", 4, S_UP, 0, 0, 0);
    chk("mid_c5", 5, S_UP, 0, 0, 0);
    chk("mid_c6", 6, S_UP, 0, 0, 0);
    rst = 1; act = 0;
    chk("mid_rst0", 0, S_IDLE, 0, 0, 0);
    chk("mid_rst1", 0, S_IDLE, 0, 0, 0);
    rst = 0;

    // WRAP down
    load = 1; load_val = 2;
    chk("wrap_load", 2, S_IDLE, 0, 0, 0);
    load = 0; act = 1; up_dwn = 0;
    chk("wrap_enter", 2, S_DWN, 0, 0, 0);
    chk("wrap_c1", 1, S_DWN, 0, 0, 0);
    chk("wrap_c0", 0, S_DWN, 0, 0, 0);
    chk("wrap_c9", 9, S_DWN, 0, 1, 1);
    chk("wrap_c8", 8, S_DWN, 0, 1, 0);
    chk("wrap_c7", 7, S_DWN, 0, 1, 0);
    act = 0;
    chk("wrap_stop", 6, S_IDLE, 0, 1, 0);
    ovf_clr = 1;
    chk("wrap_clr", 6, S_IDLE, 0, 0, 0);
    ovf_clr = 0;

    // SAT up at 15, then reverse
    max_val = 15; mode = 2'b10; load = 1; load_val = 14;
    chk("sat_load", 14, S_IDLE, 0, 0, 0);
    load = 0; act = 1; up_dwn = 1;
    chk("sat_enter", 14, S_UP, 0, 0, 0);
    chk("sat_c15", 15, S_UP, 0, 0, 0);
    chk("sat_pin0", 15, S_UP, 1, 0, 1);
    chk("sat_pin1", 15, S_UP, 1, 0, 1);
    up_dwn = 0;
    chk("sat_rev", 15, S_DWN, 1, 0, 1);
    chk("sat_c14", 14, S_DWN, 1, 0, 0);
    chk("sat_c13", 13, S_DWN, 1, 0, 0);

    // load clamp, load during CNT_UP
    act = 0; mode = 2'b00; max_val = 7; load = 1; load_val = 12;
    chk("clamp", 7, S_IDLE, 0, 0, 0);
    load = 0; act = 1; up_dwn = 1; max_val = 15;
    chk("ld_enter", 7, S_UP, 0, 0, 0);
    chk("ld_c8", 8, S_UP, 0, 0, 0);
    load = 1; load_val = 3;
    chk("ld_in_up", 3, S_IDLE, 0, 0, 0);
    load = 0;
    chk("rev_enter", 3, S_UP, 0, 0, 0);

    // reversal without idle cycle, then act=0
    up_dwn = 0;
    chk("rev_c4", 4, S_DWN, 0, 0, 0);
    chk("rev_c3", 3, S_DWN, 0, 0, 0);
    chk("rev_c2", 2, S_DWN, 0, 0, 0);
    act = 0;
    chk("rev_last", 1, S_IDLE, 0, 0, 0);
    chk("rev_held", 1, S_IDLE, 0, 0, 0);

    // max_val lowered below count in CNT_UP
    load = 1; load_val = 3;
    chk("mx0_load", 3, S_IDLE, 0, 0, 0);
    load = 0; act = 1; up_dwn = 1;
    chk("mx0_enter", 3, S_UP, 0, 0, 0);
    max_val = 0;
    chk("mx0_term", 0, S_OVR, 1, 0, 1);
    act = 0;
    chk("mx0_hold", 0, S_OVR, 1, 0, 0);
    load = 1; load_val = 5; max_val = 15;
    chk("ovr_load", 5, S_IDLE, 0, 0, 0);

    // mode 11 behaves as STOP
    load_val = 14; mode = 2'b11;
    chk("m3_load", 14, S_IDLE, 0, 0, 0);
    load = 0; act = 1;
    chk("m3_enter", 14, S_UP, 0, 0, 0);
    chk("m3_c15", 15, S_UP, 0, 0, 0);
    chk("m3_term", 15, S_OVR, 1, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
